// File: rtl/range_tracker_param.sv
// Streaming min/max tracker over a go/finish session; reports range, min, max or
// midpoint of the samples, with a saturating sample count and session status.
module range_tracker_param #(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned CNT_WIDTH = 8,
  parameter bit          SIGNED    = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 go,
  input  logic                 finish,
  input  logic [1:0]           sel,
  output logic [WIDTH-1:0]     result,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 done,
  output logic                 error,
  output logic                 overflow
);

  typedef enum logic [1:0] {StIdle, StReading, StDone, StError} state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     min_q, max_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 overflow_q, done_q, error_q;

  logic                 lt_min, gt_max, active;
  logic [WIDTH:0]       min_x, max_x, sum;
  logic [WIDTH-1:0]     range_val, mid_val, sel_val;

  always_comb begin
    if (SIGNED) begin
      lt_min = $signed(data_in) < $signed(min_q);
      gt_max = $signed(data_in) > $signed(max_q);
    end else begin
      lt_min = data_in < min_q;
      gt_max = data_in > max_q;
    end
    // Extend by one bit so the sum keeps its carry (or sign) before halving.
    min_x     = {SIGNED & min_q[WIDTH-1], min_q};
    max_x     = {SIGNED & max_q[WIDTH-1], max_q};
    sum       = min_x + max_x;
    mid_val   = WIDTH'(sum >> 1);
    range_val = max_q - min_q;
    active    = (state_q == StReading) || (state_q == StDone);
    case (sel)
      2'b00:   sel_val = range_val;
      2'b01:   sel_val = min_q;
      2'b10:   sel_val = max_q;
      default: sel_val = mid_val;
    endcase
    result   = active ? sel_val : '0;
    count    = active ? count_q : '0;
    done     = done_q;
    error    = error_q;
    overflow = overflow_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      min_q      <= '0;
      max_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (finish) begin
            state_q <= StError;
            error_q <= 1'b1;
          end else if (go) begin
            state_q    <= StReading;
            min_q      <= data_in;
            max_q      <= data_in;
            count_q    <= CNT_WIDTH'(1);
            overflow_q <= 1'b0;
          end
        end
        StReading: begin
          if (finish) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            if (lt_min) min_q <= data_in;
            if (gt_max) max_q <= data_in;
            if (count_q == {CNT_WIDTH{1'b1}}) overflow_q <= 1'b1;
            else count_q <= count_q + CNT_WIDTH'(1);
          end
        end
        StDone: begin
          if (!finish) begin
            done_q <= 1'b0;
            if (go) begin
              // Back-to-back session: this cycle's sample is the first one.
              state_q    <= StReading;
              min_q      <= data_in;
              max_q      <= data_in;
              count_q    <= CNT_WIDTH'(1);
              overflow_q <= 1'b0;
            end else begin
              state_q    <= StIdle;
              min_q      <= '0;
              max_q      <= '0;
              count_q    <= '0;
              overflow_q <= 1'b0;
            end
          end
        end
        StError: begin
          if (go && !finish) begin
            state_q    <= StReading;
            error_q    <= 1'b0;
            min_q      <= data_in;
            max_q      <= data_in;
            count_q    <= CNT_WIDTH'(1);
            overflow_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
